sisc_exec_ctrl: RTL and testbench
=================================

// Module: sisc_exec_ctrl
// PURPOSE
//  Execution/control core of the SISC processor: a multicycle control FSM, the 32-bit ALU and the branch-address unit.
//  Sits between IR/RF/status register (inputs) and PC/DM/RF-writeback muxes (control outputs).
//  Instruction fields: op=[31:28], mm/funct=[27:24], rd=[23:20], rs=[19:16], rt=[15:12], imm=[15:0].
// PARAMETERS
//  none (data width 32, address width 16, status width 4 are fixed)
// PORTS
//  clk         in   1   system clock, all state on rising edge
//  rst_f       in   1   one clock; reset is synchronous and active-high
//  instr       in   32  current instruction from IR
//  rsa         in   32  RF port A data (R[rs])
//  rsb         in   32  RF port B data (R[rt], or R[rd] when rb_sel=1)
//  pc_out      in   16  current PC (already incremented after FETCH)
//  stat        in   4   stored status {C,V,N,Z}; stat[3]=carry-in
//  alu_result  out  32  ALU result (combinational); [15:0] is DM address for LOD/STR
//  stat_next   out  4   new status {C,V,N,Z} computed by ALU
//  stat_en     out  4   per-bit status-register write enables
//  br_addr     out  16  branch target
//  br_sel      out  1   1=absolute target, 0=PC-relative
//  pc_sel      out  1   1=PC loads br_addr, 0=PC+1
//  pc_write    out  1   PC write enable
//  pc_rst      out  1   PC clear
//  ir_load     out  1   IR load enable
//  rf_we       out  1   RF write enable
//  wb_sel      out  1   writeback mux: 0=alu_result, 1=DM data
//  mm_sel      out  1   memory address mux: 0=PC (IM), 1=alu_result[15:0] (DM)
//  dm_we       out  1   DM write enable
//  rb_sel      out  1   RF port-B address: 0=instr[15:12], 1=instr[23:20]
// BEHAVIOUR
//  Opcodes: 0000 NOP, 0001 ALU reg, 0010 ALU imm, 0011 LOD, 0100 STR, 0101 BRA, 0110 BRR, 0111 BNE, 1000 BNR, 1111 HLT; others = NOP.
//  FSM states: RESET, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT.
//  Transitions: rst_f=1 forces RESET from any state (mid-instruction aborted, no writes).
//  RESET->FETCH->DECODE->EXECUTE->MEM->WRITEBACK->FETCH. DECODE->HALT on HLT; HALT held until rst_f.
//  Outputs default 0 in every state; asserted only as follows:
//   RESET: pc_rst=1.
//   FETCH: ir_load=1, pc_write=1, pc_sel=0, mm_sel=0.
//   DECODE: taken branch -> pc_sel=1, pc_write=1 (one cycle); br_sel=1 for BRA/BNE, 0 for BRR/BNR.
//   EXECUTE: ALU reg/imm -> stat_en per funct (one-cycle pulse).
//   MEM: LOD/STR -> mm_sel=1; STR -> dm_we=1 (exactly one cycle).
//   WRITEBACK: ALU reg/imm -> rf_we=1, wb_sel=0; LOD -> rf_we=1, wb_sel=1, mm_sel=1. Writes go to rd.
//   rb_sel=1 for STR in DECODE, EXECUTE and MEM.
//  Branch condition: BRA/BRR taken if mm==0000 or (mm & stat)!=0.
//   BNE/BNR taken if (mm & stat)==0. Not-taken: no PC write.
//  br_addr = br_sel ? imm : pc_out + imm (imm as 16-bit two's complement, wraps mod 2^16).
//  ALU operand b: rsb for op 0001; sign-extended imm for op 0010.
//  funct 0001 ADD a+b; 0010 ADC a+b+C; 0011 SUB a+~b+1; stat_en=1111.
//   Arithmetic flags: C=carry-out bit 32 (SUB: 1=no borrow); V=signed overflow; N=r[31]; Z=(r==0).
//  funct 0100 AND, 0101 OR, 0110 XOR, 0111 NOT(~a): stat_en=0011 (N,Z only); C,V outputs 0.
//  funct 1000 SHL, 1001 SHR logical, 1010 ASR: shift a by b[4:0]; stat_en=1011.
//   Shift C = last bit shifted out, 0 if amount 0.
//  Other funct: result 0, stat_en=0000.
//  LOD/STR address: mm=0001 -> rsa + sext(imm); any other mm -> zero-ext imm. stat_en=0000. Upper 16 result bits ignored.
//  alu_result/stat_next are combinational and valid whenever instr/rsa/rsb are stable; stat_en is never asserted outside EXECUTE.
//  NOP/undefined opcodes traverse all five states with no write enables.
//  CPI = 5 for every opcode except HLT.
// TESTING
//  Reset: rst_f=1 two cycles -> pc_rst=1, all other outputs 0; release -> RESET, then FETCH with ir_load=pc_write=1, pc_sel=0.
//  ADD 0x11312000, rsa=0x7FFFFFFF, rsb=1 -> alu_result=0x80000000, stat_next=4'b0110.
//   Also: stat_en=1111 in EXECUTE only; rf_we=1, wb_sel=0 in WRITEBACK.
//  LOD 0x30100008 -> MEM: mm_sel=1, alu_result[15:0]=0x0008; WRITEBACK: rf_we=1, wb_sel=1, rb_sel=0.
//  STR 0x41210001, rsa=8 -> address 0x0009, dm_we=1 for one MEM cycle, rb_sel=1 DECODE..MEM, rf_we never.
//  BRR 0x61000FFFD-style (op 0110, mm 0001, imm 0xFFFD), pc_out=0x0005:
//   stat=0001 -> DECODE: br_addr=0x0002, br_sel=0, pc_sel=pc_write=1.
//   stat=0000 -> no pc_write.
//  HLT 0xF0000000 -> HALT, all enables 0 for 20+ cycles; rst_f pulse -> RESET then FETCH.

Source files
------------

// File: rtl/sisc_exec_ctrl.sv
// SISC execution/control core: multicycle control FSM, 32-bit ALU and
// branch-address unit.
//
// Ports:
//   clk, rst_f           clock; synchronous active-high reset
//   instr                current instruction from IR
//   rsa, rsb             RF read data (rsb = R[rt], or R[rd] when rb_sel=1)
//   pc_out               current (already incremented) PC
//   stat                 stored status {C,V,N,Z}
//   alu_result           ALU result; [15:0] is the DM address for LOD/STR
//   stat_next, stat_en   new status and per-bit status write enables
//   br_addr, br_sel      branch target and absolute/relative select
//   pc_sel, pc_write     PC source select and write enable
//   pc_rst, ir_load      PC clear and IR load
//   rf_we, wb_sel        RF write enable and writeback source
//   mm_sel, dm_we        memory address source and DM write enable
//   rb_sel               RF port-B address select
module sisc_exec_ctrl (
    input  logic        clk,
    input  logic        rst_f,
    input  logic [31:0] instr,
    input  logic [31:0] rsa,
    input  logic [31:0] rsb,
    input  logic [15:0] pc_out,
    input  logic [3:0]  stat,
    output logic [31:0] alu_result,
    output logic [3:0]  stat_next,
    output logic [3:0]  stat_en,
    output logic [15:0] br_addr,
    output logic        br_sel,
    output logic        pc_sel,
    output logic        pc_write,
    output logic        pc_rst,
    output logic        ir_load,
    output logic        rf_we,
    output logic        wb_sel,
    output logic        mm_sel,
    output logic        dm_we,
    output logic        rb_sel
);

    typedef enum logic [2:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WRITEBACK,
        S_HALT
    } state_t;

    state_t state, state_nxt;

    logic [3:0]  op;
    logic [3:0]  mm;
    logic [15:0] imm;
    logic [31:0] imm_sext;

    assign op       = instr[31:28];
    assign mm       = instr[27:24];
    assign imm      = instr[15:0];
    assign imm_sext = {{16{imm[15]}}, imm};

    // Register fields are consumed by the RF outside this block.
    logic unused_fields;
    assign unused_fields = ^instr[23:16];

    logic is_alu_r, is_alu_i, is_alu, is_lod, is_str;
    logic is_bra, is_brr, is_bne, is_bnr, is_hlt;

    assign is_alu_r = (op == 4'b0001);
    assign is_alu_i = (op == 4'b0010);
    assign is_alu   = is_alu_r | is_alu_i;
    assign is_lod   = (op == 4'b0011);
    assign is_str   = (op == 4'b0100);
    assign is_bra   = (op == 4'b0101);
    assign is_brr   = (op == 4'b0110);
    assign is_bne   = (op == 4'b0111);
    assign is_bnr   = (op == 4'b1000);
    assign is_hlt   = (op == 4'b1111);

    // Branch condition and target.
    logic br_abs;
    logic br_taken;
    logic any_hit;

    assign any_hit = |(mm & stat);
    assign br_abs  = is_bra | is_bne;
    assign br_addr = br_abs ? imm : pc_out + imm;

    always_comb begin
        br_taken = 1'b0;
        unique case (1'b1)
            is_bra, is_brr: br_taken = (mm == 4'b0000) | any_hit;
            is_bne, is_bnr: br_taken = ~any_hit;
            default:        br_taken = 1'b0;
        endcase
    end

    // ALU
    logic [31:0] b_opnd;
    logic [31:0] res;
    logic        c_flag;
    logic        v_flag;
    logic [3:0]  alu_en;
    logic [4:0]  sh;

    assign b_opnd = is_alu_i ? imm_sext : rsb;
    assign sh     = b_opnd[4:0];

    always_comb begin
        res    = '0;
        c_flag = 1'b0;
        v_flag = 1'b0;
        alu_en = 4'b0000;
        if (is_alu) begin
            unique case (mm)
                4'h1: begin
                    {c_flag, res} = {1'b0, rsa} + {1'b0, b_opnd};
                    v_flag = (rsa[31] == b_opnd[31]) &&
                             (res[31] != rsa[31]);
                    alu_en = 4'b1111;
                end
                4'h2: begin
                    {c_flag, res} = {1'b0, rsa} + {1'b0, b_opnd}
                                  + {32'd0, stat[3]};
                    v_flag = (rsa[31] == b_opnd[31]) &&
                             (res[31] != rsa[31]);
                    alu_en = 4'b1111;
                end
                4'h3: begin
                    // Carry out is "no borrow".
                    {c_flag, res} = {1'b0, rsa} + {1'b0, ~b_opnd}
                                  + 33'd1;
                    v_flag = (rsa[31] != b_opnd[31]) &&
                             (res[31] != rsa[31]);
                    alu_en = 4'b1111;
                end
                4'h4: begin
                    res    = rsa & b_opnd;
                    alu_en = 4'b0011;
                end
                4'h5: begin
                    res    = rsa | b_opnd;
                    alu_en = 4'b0011;
                end
                4'h6: begin
                    res    = rsa ^ b_opnd;
                    alu_en = 4'b0011;
                end
                4'h7: begin
                    res    = ~rsa;
                    alu_en = 4'b0011;
                end
                // Shifts use a 33-bit window so the last bit shifted
                // out lands in the carry position; zero when sh==0.
                4'h8: begin
                    {c_flag, res} = {1'b0, rsa} << sh;
                    alu_en = 4'b1011;
                end
                4'h9: begin
                    {res, c_flag} = {rsa, 1'b0} >> sh;
                    alu_en = 4'b1011;
                end
                4'hA: begin
                    {res, c_flag} = $signed({rsa, 1'b0}) >>> sh;
                    alu_en = 4'b1011;
                end
                default: begin
                    res    = '0;
                    alu_en = 4'b0000;
                end
            endcase
        end else if (is_lod || is_str) begin
            res = (mm == 4'b0001) ? rsa + imm_sext : {16'd0, imm};
        end
    end

    assign alu_result = res;
    assign stat_next  = {c_flag, v_flag, res[31], (res == 32'd0)};

    // FSM
    always_ff @(posedge clk) begin
        if (rst_f) begin
            state <= S_RESET;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_rst    = 1'b0;
        ir_load   = 1'b0;
        pc_write  = 1'b0;
        pc_sel    = 1'b0;
        br_sel    = 1'b0;
        stat_en   = 4'b0000;
        rf_we     = 1'b0;
        wb_sel    = 1'b0;
        mm_sel    = 1'b0;
        dm_we     = 1'b0;
        rb_sel    = 1'b0;
        // Reset overrides the current state immediately so an aborted
        // instruction cannot write anything during the reset cycle.
        if (rst_f) begin
            state_nxt = S_RESET;
            pc_rst    = 1'b1;
        end else begin
            unique case (state)
                S_RESET: begin
                    pc_rst    = 1'b1;
                    state_nxt = S_FETCH;
                end
                S_FETCH: begin
                    ir_load   = 1'b1;
                    pc_write  = 1'b1;
                    state_nxt = S_DECODE;
                end
                S_DECODE: begin
                    br_sel    = br_abs;
                    pc_sel    = br_taken;
                    pc_write  = br_taken;
                    rb_sel    = is_str;
                    state_nxt = is_hlt ? S_HALT : S_EXECUTE;
                end
                S_EXECUTE: begin
                    stat_en   = alu_en;
                    rb_sel    = is_str;
                    state_nxt = S_MEM;
                end
                S_MEM: begin
                    mm_sel    = is_lod | is_str;
                    dm_we     = is_str;
                    rb_sel    = is_str;
                    state_nxt = S_WRITEBACK;
                end
                S_WRITEBACK: begin
                    rf_we     = is_alu | is_lod;
                    wb_sel    = is_lod;
                    mm_sel    = is_lod;
                    state_nxt = S_FETCH;
                end
                S_HALT: begin
                    state_nxt = S_HALT;
                end
                default: begin
                    state_nxt = S_RESET;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sisc_exec_ctrl.sv
// Scoreboard bench for sisc_exec_ctrl: driver pushes per-cycle
// expectations from a reference model, monitor pops and compares.
module tb_sisc_exec_ctrl;

    logic        clk;
    logic        rst_f;
    logic [31:0] instr;
    logic [31:0] rsa;
    logic [31:0] rsb;
    logic [15:0] pc_out;
    logic [3:0]  stat;
    logic [31:0] alu_result;
    logic [3:0]  stat_next;
    logic [3:0]  stat_en;
    logic [15:0] br_addr;
    logic        br_sel;
    logic        pc_sel;
    logic        pc_write;
    logic        pc_rst;
    logic        ir_load;
    logic        rf_we;
    logic        wb_sel;
    logic        mm_sel;
    logic        dm_we;
    logic        rb_sel;

    sisc_exec_ctrl dut (
        .clk        (clk),
        .rst_f      (rst_f),
        .instr      (instr),
        .rsa        (rsa),
        .rsb        (rsb),
        .pc_out     (pc_out),
        .stat       (stat),
        .alu_result (alu_result),
        .stat_next  (stat_next),
        .stat_en    (stat_en),
        .br_addr    (br_addr),
        .br_sel     (br_sel),
        .pc_sel     (pc_sel),
        .pc_write   (pc_write),
        .pc_rst     (pc_rst),
        .ir_load    (ir_load),
        .rf_we      (rf_we),
        .wb_sel     (wb_sel),
        .mm_sel     (mm_sel),
        .dm_we      (dm_we),
        .rb_sel     (rb_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control bundle bit positions.
    localparam int PC_RST = 13;
    localparam int IR_LD  = 12;
    localparam int PC_WR  = 11;
    localparam int PC_SEL = 10;
    localparam int BR_SEL = 9;
    localparam int RF_WE  = 8;
    localparam int WB_SEL = 7;
    localparam int MM_SEL = 6;
    localparam int DM_WE  = 5;
    localparam int RB_SEL = 4;

    typedef struct {
        int          tag;
        logic [13:0] ctrl;
        bit          chk_alu;
        logic [31:0] alu_mask;
        logic [31:0] alu_exp;
        logic [3:0]  st_mask;
        logic [3:0]  st_exp;
        bit          chk_br;
        logic [15:0] br_exp;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   tag_ctr  = 0;

    // Reference ALU computed from the instruction-set rules.
    function automatic void model_alu(
        input  logic [31:0] ins,
        input  logic [31:0] a,
        input  logic [31:0] rbv,
        input  logic [3:0]  st,
        output logic [31:0] r,
        output logic [3:0]  fl,
        output logic [3:0]  en,
        output logic [3:0]  fm
    );
        logic [3:0]  op;
        logic [3:0]  fn;
        logic [31:0] b;
        logic [31:0] bb;
        logic [31:0] sx;
        logic [63:0] u;
        longint      s;
        int          n;
        int          ci;
        bit          c;
        bit          v;
        op = ins[31:28];
        fn = ins[27:24];
        sx = {{16{ins[15]}}, ins[15:0]};
        b  = (op == 4'd2) ? sx : rbv;
        n  = int'(b[4:0]);
        r  = 0;
        c  = 0;
        v  = 0;
        en = 0;
        fm = 0;
        if (op == 4'd3 || op == 4'd4) begin
            r = (fn == 4'd1) ? a + sx : {16'h0, ins[15:0]};
        end else begin
            case (fn)
                4'd1, 4'd2, 4'd3: begin
                    bb = (fn == 4'd3) ? ~b : b;
                    ci = (fn == 4'd3) ? 1 :
                         (fn == 4'd2) ? int'(st[3]) : 0;
                    u  = 64'(a) + 64'(bb) + 64'(ci);
                    s  = longint'($signed(a)) + longint'($signed(bb))
                       + longint'(ci);
                    r  = u[31:0];
                    c  = u[32];
                    v  = (s > 64'sd2147483647) ||
                         (s < -64'sd2147483648);
                    en = 4'b1111;
                    fm = 4'b1111;
                end
                4'd4: begin r = a & b; en = 4'b0011; fm = 4'b1111; end
                4'd5: begin r = a | b; en = 4'b0011; fm = 4'b1111; end
                4'd6: begin r = a ^ b; en = 4'b0011; fm = 4'b1111; end
                4'd7: begin r = ~a;    en = 4'b0011; fm = 4'b1111; end
                4'd8: begin
                    r  = a << n;
                    c  = (n == 0) ? 1'b0 : a[32-n];
                    en = 4'b1011;
                    fm = 4'b1011;
                end
                4'd9: begin
                    r  = a >> n;
                    c  = (n == 0) ? 1'b0 : a[n-1];
                    en = 4'b1011;
                    fm = 4'b1011;
                end
                4'd10: begin
                    r  = $signed(a) >>> n;
                    c  = (n == 0) ? 1'b0 : a[n-1];
                    en = 4'b1011;
                    fm = 4'b1011;
                end
                default: begin
                    r  = 0;
                    en = 0;
                    fm = 0;
                end
            endcase
        end
        fl = {c, v, r[31], (r == 32'd0)};
    endfunction

    // Expected bundle for one instruction phase (0=FETCH .. 4=WB).
    function automatic exp_t model_phase(
        input logic [31:0] ins,
        input logic [31:0] a,
        input logic [31:0] rbv,
        input logic [3:0]  st,
        input logic [15:0] pc,
        input int          ph
    );
        exp_t        e;
        logic [3:0]  op;
        logic [3:0]  mmv;
        logic [31:0] r;
        logic [3:0]  fl;
        logic [3:0]  en;
        logic [3:0]  fm;
        bit          alu_op;
        bit          ldst;
        bit          brn;
        bit          taken;
        op     = ins[31:28];
        mmv    = ins[27:24];
        alu_op = (op == 4'd1) || (op == 4'd2);
        ldst   = (op == 4'd3) || (op == 4'd4);
        brn    = (op >= 4'd5) && (op <= 4'd8);
        if (op == 4'd5 || op == 4'd6)
            taken = (mmv == 0) || ((mmv & st) != 0);
        else
            taken = brn && ((mmv & st) == 0);
        model_alu(ins, a, rbv, st, r, fl, en, fm);
        e          = '{default: '0};
        e.tag      = tag_ctr;
        case (ph)
            0: begin
                e.ctrl[IR_LD] = 1'b1;
                e.ctrl[PC_WR] = 1'b1;
            end
            1: begin
                e.ctrl[PC_WR]  = taken;
                e.ctrl[PC_SEL] = taken;
                e.ctrl[BR_SEL] = (op == 4'd5) || (op == 4'd7);
                e.ctrl[RB_SEL] = (op == 4'd4);
                if (brn) begin
                    e.chk_br = 1;
                    e.br_exp = (op == 4'd5 || op == 4'd7) ?
                               ins[15:0] : 16'(pc + ins[15:0]);
                end
            end
            2: begin
                e.ctrl[3:0]    = alu_op ? en : 4'b0000;
                e.ctrl[RB_SEL] = (op == 4'd4);
                if (alu_op) begin
                    e.chk_alu  = 1;
                    e.alu_mask = 32'hFFFF_FFFF;
                    e.alu_exp  = r;
                    e.st_mask  = fm;
                    e.st_exp   = fl;
                end
            end
            3: begin
                e.ctrl[MM_SEL] = ldst;
                e.ctrl[DM_WE]  = (op == 4'd4);
                e.ctrl[RB_SEL] = (op == 4'd4);
                if (ldst) begin
                    e.chk_alu  = 1;
                    e.alu_mask = 32'h0000_FFFF;
                    e.alu_exp  = r;
                end
            end
            default: begin
                e.ctrl[RF_WE]  = alu_op || (op == 4'd3);
                e.ctrl[WB_SEL] = (op == 4'd3);
                e.ctrl[MM_SEL] = (op == 4'd3);
            end
        endcase
        return e;
    endfunction

    function automatic exp_t only_ctrl(input logic [13:0] c);
        exp_t e;
        e      = '{default: '0};
        e.tag  = tag_ctr;
        e.ctrl = c;
        return e;
    endfunction

    // Monitor: compares at the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t        e;
        logic [13:0] act;
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            act = {pc_rst, ir_load, pc_write, pc_sel, br_sel, rf_we,
                   wb_sel, mm_sel, dm_we, rb_sel, stat_en};
            checks++;
            if (act !== e.ctrl) begin
                failures++;
                $display("FAIL ctrl tag=%0d got=%b want=%b",
                         e.tag, act, e.ctrl);
            end
            if (e.chk_alu) begin
                checks++;
                if ((alu_result & e.alu_mask) !==
                    (e.alu_exp & e.alu_mask)) begin
                    failures++;
                    $display("FAIL alu tag=%0d instr=%h got=%h want=%h",
                             e.tag, instr, alu_result & e.alu_mask,
                             e.alu_exp & e.alu_mask);
                end
                if (e.st_mask != 4'b0000) begin
                    checks++;
                    if ((stat_next & e.st_mask) !==
                        (e.st_exp & e.st_mask)) begin
                        failures++;
                        $display("FAIL stat tag=%0d instr=%h got=%b want=%b",
                                 e.tag, instr, stat_next & e.st_mask,
                                 e.st_exp & e.st_mask);
                    end
                end
            end
            if (e.chk_br) begin
                checks++;
                if (br_addr !== e.br_exp) begin
                    failures++;
                    $display("FAIL br_addr tag=%0d got=%h want=%h",
                             e.tag, br_addr, e.br_exp);
                end
            end
        end
    end

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rst_f = 1'b1;
            sb.push_back(only_ctrl(14'(1) << PC_RST));
        end
        @(posedge clk);
        #1;
        rst_f = 1'b0;
        sb.push_back(only_ctrl(14'(1) << PC_RST));
    endtask

    task automatic run_instr(
        input logic [31:0] ins,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [3:0]  st,
        input logic [15:0] pc
    );
        tag_ctr++;
        for (int ph = 0; ph < 5; ph++) begin
            @(posedge clk);
            #1;
            instr  = ins;
            rsa    = a;
            rsb    = b;
            stat   = st;
            pc_out = pc;
            sb.push_back(model_phase(ins, a, b, st, pc, ph));
        end
    endtask

    task automatic run_halt(input int n);
        tag_ctr++;
        for (int ph = 0; ph < 2; ph++) begin
            @(posedge clk);
            #1;
            instr = 32'hF000_0000;
            sb.push_back(model_phase(instr, rsa, rsb, stat, pc_out, ph));
        end
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            sb.push_back(only_ctrl(14'd0));
        end
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [3:0]  rop;
        logic [31:0] ri;
        int          wait_cnt;
        rst_f  = 1'b1;
        instr  = 32'd0;
        rsa    = 32'd0;
        rsb    = 32'd0;
        pc_out = 16'd0;
        stat   = 4'd0;

        do_reset(2);

        run_instr(32'h1131_2000, 32'h7FFF_FFFF, 32'd1, 4'h0, 16'h0001);
        run_instr(32'h3010_0008, 32'h0000_1234, 32'd0, 4'h0, 16'h0002);
        run_instr(32'h4121_0001, 32'h0000_0008, 32'hAB, 4'h0, 16'h0003);
        run_instr(32'h6100_FFFD, 32'd0, 32'd0, 4'b0001, 16'h0005);
        run_instr(32'h6100_FFFD, 32'd0, 32'd0, 4'b0000, 16'h0005);
        run_instr(32'h5000_0040, 32'd0, 32'd0, 4'b0000, 16'h0010);
        run_instr(32'h7400_0020, 32'd0, 32'd0, 4'b0010, 16'h0011);
        run_instr(32'h8400_0003, 32'd0, 32'd0, 4'b0100, 16'hFFFF);
        run_instr(32'h1231_2000, 32'hFFFF_FFFF, 32'd0, 4'b1000, 16'h0);
        run_instr(32'h1331_2000, 32'd5, 32'd7, 4'h0, 16'h0);
        run_instr(32'h2831_0000, 32'h8000_0001, 32'd0, 4'h0, 16'h0);
        run_instr(32'h2A31_001F, 32'h8000_0000, 32'd0, 4'h0, 16'h0);
        run_instr(32'h2931_0004, 32'h0000_0018, 32'd0, 4'h0, 16'h0);
        run_instr(32'h1F31_2000, 32'd9, 32'd9, 4'h0, 16'h0);
        run_instr(32'h9000_0000, 32'd1, 32'd2, 4'hF, 16'h0);
        run_instr(32'h0000_0000, 32'd1, 32'd2, 4'hF, 16'h0);

        for (int i = 0; i < 120; i++) begin
            rop = 4'($urandom_range(0, 14));
            ri  = $urandom;
            ri[31:28] = rop;
            run_instr(ri, pick_val(), pick_val(), 4'($urandom),
                      16'($urandom));
        end

        run_halt(22);
        do_reset(1);
        run_instr(32'h0000_0000, 32'd0, 32'd0, 4'h0, 16'h0);
        run_instr(32'h1131_2000, 32'd3, 32'd4, 4'h0, 16'h0);

        // Abort mid-instruction: reset during EXECUTE of a store.
        tag_ctr++;
        for (int ph = 0; ph < 2; ph++) begin
            @(posedge clk);
            #1;
            instr = 32'h4121_0001;
            sb.push_back(model_phase(instr, rsa, rsb, stat, pc_out, ph));
        end
        do_reset(1);
        run_instr(32'h0000_0000, 32'd0, 32'd0, 4'h0, 16'h0);

        wait_cnt = 0;
        while (sb.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain left=%0d want=0", sb.size());
        end
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
